var_shift_seq: RTL and testbench

Iterative, handshaked variable shifter that moves a 32-bit word one bit position per clock until the requested shift amount is consumed. It accepts a command (word, amount, direction, mode) on a valid/ready request port and returns the result on a valid/ready response port. It is the multi-cycle, flow-controlled counterpart to the single-cycle `var_shift` datapath. It sits between a command source and a result consumer that both apply backpressure.

---
 rtl/var_shift_seq_if.sv | 28 ++
 rtl/var_shift_seq.sv | 119 +++++++++++
 tb/tb_var_shift_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/var_shift_seq_if.sv
// Command/response bundle for the iterative shifter: a valid/ready command port,
// a valid/ready result port, the shift enable and the busy status.
interface var_shift_seq_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 6
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] in;
    logic [SHW-1:0]   shift;
    logic             dir;
    logic             arith;
    logic             en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic             busy;

    modport master (
        output start_valid, in, shift, dir, arith, en, out_ready,
        input  start_ready, out_valid, q, busy
    );

    modport slave (
        input  start_valid, in, shift, dir, arith, en, out_ready,
        output start_ready, out_valid, q, busy
    );
endinterface

// File: rtl/var_shift_seq.sv
// Multi-cycle variable shifter: one bit position per enabled clock, with
// valid/ready flow control on both the command and the result side.
module var_shift_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 6
) (
    input  logic          clk,
    input  logic          clr_n,
    var_shift_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int MW = (SHW > CW) ? SHW : CW;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_cnt;
    logic             r_dir;
    logic             r_arith;
    logic             r_start_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [CW-1:0]    w_k;

    // One-position step; the sign fill only matters for arithmetic right shifts.
    function automatic logic [WIDTH-1:0] step_one(input logic [WIDTH-1:0] d,
                                                  input logic right,
                                                  input logic arith);
        logic fill;
        fill = arith & d[WIDTH-1];
        if (right) begin
            step_one = {fill, d[WIDTH-1:1]};
        end else begin
            step_one = {d[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Clamp the requested amount to WIDTH so oversize amounts cost exactly WIDTH steps.
    always_comb begin
        w_k = CNT_ZERO;
        if (MW'(bus.shift) >= MW'(WIDTH)) begin
            w_k = CW'(WIDTH);
        end else begin
            w_k = CW'(bus.shift);
        end
    end

    // Control FSM and datapath; status outputs are registered alongside the state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state       <= ST_IDLE;
            r_data        <= {WIDTH{1'b0}};
            r_cnt         <= CNT_ZERO;
            r_dir         <= 1'b0;
            r_arith       <= 1'b0;
            r_start_ready <= 1'b1;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_valid) begin
                        r_data        <= bus.in;
                        r_cnt         <= w_k;
                        r_dir         <= bus.dir;
                        r_arith       <= bus.arith;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        if (w_k == CNT_ZERO) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state     <= ST_SHIFT;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bus.en) begin
                        r_data <= step_one(r_data, r_dir, r_arith);
                        r_cnt  <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state       <= ST_IDLE;
                        r_out_valid   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_cnt         <= CNT_ZERO;
                    r_start_ready <= 1'b1;
                    r_out_valid   <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready = r_start_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.busy        = r_busy;
    assign bus.q           = r_data;

endmodule

// File: tb/tb_var_shift_seq.sv
// Self-checking bench for var_shift_seq: directed scenarios plus randomized
// commands against a plain-arithmetic shift model.
module tb_var_shift_seq;
    localparam int W  = 32;
    localparam int SW = 6;

    logic clk = 1'b0;
    logic clr_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    var_shift_seq_if #(.WIDTH(W), .SHW(SW)) vif();

    var_shift_seq #(.WIDTH(W), .SHW(SW)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (vif.slave)
    );

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int n,
                                              input logic dr, input logic ar);
        if (n >= 32) begin
            if (dr && ar) return {32{d[31]}};
            return 32'h0;
        end
        if (!dr) return d << n;
        if (ar) return 32'($signed(d) >>> n);
        return d >> n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vif.start_valid = 1'b0;
        vif.in          = 32'h0;
        vif.shift       = 6'd0;
        vif.dir         = 1'b0;
        vif.arith       = 1'b0;
        vif.en          = 1'b1;
        vif.out_ready   = 1'b0;
    endtask

    // en_mode: 0 = always enabled, 1 = random enable, 2 = 3-cycle stall after first step
    task automatic do_cmd(input logic [31:0] d, input logic [5:0] sh, input logic dr,
                          input logic ar, input int en_mode, input int hold_n,
                          input string tag);
        int k;
        int ones;
        int guard;
        logic [31:0] exp_q;
        logic [31:0] mid_q;
        k     = (int'(sh) >= W) ? W : int'(sh);
        exp_q = ref_shift(d, k, dr, ar);
        guard = 0;
        while (vif.start_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        n_checks++;
        if (vif.start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start_ready: got %b want 1", tag, vif.start_ready);
        end
        vif.start_valid = 1'b1;
        vif.in          = d;
        vif.shift       = sh;
        vif.dir         = dr;
        vif.arith       = ar;
        tick();
        vif.start_valid = 1'b0;
        vif.in          = $urandom;
        vif.shift       = 6'($urandom);
        vif.dir         = 1'($urandom);
        vif.arith       = 1'($urandom);
        ones  = 0;
        guard = 0;
        while (ones < k && guard < 400) begin
            mid_q = ref_shift(d, ones, dr, ar);
            n_checks++;
            if (vif.out_valid !== 1'b0 || vif.busy !== 1'b1 || vif.q !== mid_q) begin
                n_fail++;
                $display("FAIL %s step%0d: valid=%b busy=%b q=%h want valid=0 busy=1 q=%h",
                         tag, ones, vif.out_valid, vif.busy, vif.q, mid_q);
            end
            case (en_mode)
                0:       vif.en = 1'b1;
                1:       vif.en = 1'($urandom_range(0, 1));
                default: vif.en = !(guard >= 1 && guard < 4);
            endcase
            tick();
            if (vif.en) ones++;
            guard++;
        end
        vif.en = 1'($urandom_range(0, 1));
        n_checks++;
        if (vif.out_valid !== 1'b1 || vif.q !== exp_q) begin
            n_fail++;
            $display("FAIL %s result: valid=%b q=%h want valid=1 q=%h after %0d edges",
                     tag, vif.out_valid, vif.q, exp_q, guard);
        end
        vif.out_ready = 1'b0;
        for (int i = 0; i < hold_n; i++) begin
            vif.start_valid = 1'b1;
            vif.in          = $urandom;
            vif.shift       = 6'($urandom);
            tick();
            n_checks++;
            if (vif.out_valid !== 1'b1 || vif.q !== exp_q || vif.start_ready !== 1'b0 ||
                vif.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s hold%0d: valid=%b q=%h sready=%b busy=%b want 1 %h 0 1",
                         tag, i, vif.out_valid, vif.q, vif.start_ready, vif.busy, exp_q);
            end
        end
        vif.out_ready = 1'b1;
        tick();
        vif.start_valid = 1'b0;
        vif.out_ready   = 1'b0;
        n_checks++;
        if (vif.out_valid !== 1'b0 || vif.start_ready !== 1'b1 || vif.busy !== 1'b0 ||
            vif.q !== exp_q) begin
            n_fail++;
            $display("FAIL %s release: valid=%b sready=%b busy=%b q=%h want 0 1 0 %h",
                     tag, vif.out_valid, vif.start_ready, vif.busy, vif.q, exp_q);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        clr_n = 1'b0;
        #12;
        n_checks++;
        if (vif.q !== 32'h0 || vif.out_valid !== 1'b0 || vif.busy !== 1'b0 ||
            vif.start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: q=%h valid=%b busy=%b sready=%b want 0 0 0 1",
                     vif.q, vif.out_valid, vif.busy, vif.start_ready);
        end
        @(posedge clk);
        #3 clr_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (vif.q !== 32'h0 || vif.out_valid !== 1'b0 || vif.busy !== 1'b0 ||
                vif.start_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_release: q=%h valid=%b busy=%b sready=%b want 0 0 0 1",
                         vif.q, vif.out_valid, vif.busy, vif.start_ready);
            end
        end
    endtask

    task automatic test_left();
        do_cmd(32'h000001A6, 6'd4, 1'b0, 1'b0, 0, 0, "left4");
        n_checks++;
        if (vif.q !== 32'h00001A60) begin
            n_fail++;
            $display("FAIL left4_const: q=%h want 00001a60", vif.q);
        end
    endtask

    task automatic test_right();
        do_cmd(32'h000001A6, 6'd4, 1'b1, 1'b0, 0, 0, "lsr4");
        n_checks++;
        if (vif.q !== 32'h0000001A) begin
            n_fail++;
            $display("FAIL lsr4_const: q=%h want 0000001a", vif.q);
        end
        do_cmd(32'h80000000, 6'd4, 1'b1, 1'b1, 0, 0, "asr4");
        n_checks++;
        if (vif.q !== 32'hF8000000) begin
            n_fail++;
            $display("FAIL asr4_const: q=%h want f8000000", vif.q);
        end
    endtask

    task automatic test_boundaries();
        do_cmd(32'hDEADBEEF, 6'd0, 1'b1, 1'b1, 0, 0, "zero");
        n_checks++;
        if (vif.q !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL zero_const: q=%h want deadbeef", vif.q);
        end
        do_cmd(32'hFFFFFFFF, 6'd40, 1'b0, 1'b0, 0, 0, "left40");
        n_checks++;
        if (vif.q !== 32'h0) begin
            n_fail++;
            $display("FAIL left40_const: q=%h want 00000000", vif.q);
        end
        do_cmd(32'h80000000, 6'd63, 1'b1, 1'b1, 0, 0, "asr63");
        n_checks++;
        if (vif.q !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL asr63_const: q=%h want ffffffff", vif.q);
        end
        do_cmd(32'h7FFFFFFF, 6'd32, 1'b1, 1'b1, 0, 0, "asr32pos");
        do_cmd(32'h00000001, 6'd31, 1'b0, 1'b0, 0, 0, "left31");
    endtask

    task automatic test_stall_backpressure();
        do_cmd(32'h12345678, 6'd5, 1'b1, 1'b1, 2, 0, "stall5");
        do_cmd(32'h0F0F0F0F, 6'd3, 1'b0, 1'b0, 0, 10, "backpressure");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (vif.start_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready%0d: got %b want 1", i, vif.start_ready);
            end
            do_cmd($urandom, 6'(i * 3), 1'(i), 1'b1, 0, 0, "b2b");
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (vif.start_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        vif.start_valid = 1'b1;
        vif.in          = 32'hA5A5A5A5;
        vif.shift       = 6'd20;
        vif.dir         = 1'b0;
        tick();
        vif.start_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (vif.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_busy: got %b want 1", vif.busy);
        end
        #2 clr_n = 1'b0;
        #1;
        n_checks++;
        if (vif.q !== 32'h0 || vif.busy !== 1'b0 || vif.out_valid !== 1'b0 ||
            vif.start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_now: q=%h busy=%b valid=%b sready=%b want 0 0 0 1",
                     vif.q, vif.busy, vif.out_valid, vif.start_ready);
        end
        tick();
        tick();
        @(posedge clk);
        #3 clr_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            n_checks++;
            if (vif.out_valid !== 1'b0 || vif.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_after%0d: valid=%b busy=%b want 0 0",
                         i, vif.out_valid, vif.busy);
            end
        end
        do_cmd(32'h0000F00D, 6'd8, 1'b0, 1'b0, 0, 0, "post_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_cmd($urandom, 6'($urandom_range(0, 63)), 1'($urandom), 1'($urandom),
                   1, $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        test_reset();
        test_left();
        test_right();
        test_boundaries();
        test_stall_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
